// File: rtl/pico_pkg.sv
// rtl/pico_pkg.sv - pico core shared types plus decode-stage state enum and opcode helpers
package pico_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00, OP_MUL  = 5'h01, OP_AND  = 5'h02, OP_OR   = 5'h03,
    OP_XOR  = 5'h04, OP_NOT  = 5'h05, OP_SUB  = 5'h08, OP_BEQ  = 5'h09,
    OP_BNE  = 5'h0a, OP_HALT = 5'h0f, OP_ADDI = 5'h10, OP_MULI = 5'h11,
    OP_ANDI = 5'h12, OP_ORI  = 5'h13, OP_XORI = 5'h14, OP_NOTI = 5'h15,
    OP_SUBI = 5'h18
  } opCode;

  typedef enum logic [2:0] {
    F_ADD = 3'd0, F_MUL = 3'd1, F_AND = 3'd2, F_OR = 3'd3,
    F_XOR = 3'd4, F_NOT = 3'd5, F_SUB = 3'd6, F_PASS = 3'd7
  } funcALU;

  typedef enum logic [1:0] {
    INCREMENT = 2'd0, RELATIVE = 2'd1, ABSOLUTE = 2'd2, HALTCOUNT = 2'd3
  } modePC;

  typedef struct packed {
    logic zero;
  } flagsALU;

  typedef enum logic [1:0] {S_RUN, S_BRANCH, S_MUL, S_HALT} decState;

  function automatic logic is_wr_op(opCode op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_ADDI, OP_SUBI, OP_MULI, OP_ANDI, OP_ORI, OP_XORI, OP_NOTI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(opCode op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_mul(opCode op);
    return (op == OP_MUL) || (op == OP_MULI);
  endfunction

  // Ops that travel on to execute; HALT and unknown encodings stop here.
  function automatic logic is_fwd_op(opCode op);
    return is_wr_op(op) || is_branch(op);
  endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// rtl/dec_scoreboard.sv - busy bit per register; issue set beats writeback clear, r0 never busy
module dec_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en_i,
  input  logic [RA_W-1:0]     set_addr_i,
  input  logic                clr_en_i,
  input  logic [RA_W-1:0]     clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/dec_pipe.sv
// rtl/dec_pipe.sv - registered decode stage with hazard scoreboard and PC-control FSM
// Optional feature macro: DEC_MUL_MULTICYCLE_EN (multi-cycle MUL/MULI occupancy).
module dec_pipe
  import pico_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = $clog2(NUM_REGS),
  parameter int MUL_LAT  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  opCode           op_code_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic [RA_W-1:0] rs_i,
  input  logic [RA_W-1:0] rt_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output opCode           ex_op_o,
  output funcALU          ex_func_alu_o,
  output logic            ex_a_imm_alu_o,
  output logic            ex_wr_en_rf_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic [RA_W-1:0] ex_rs_o,
  output logic [RA_W-1:0] ex_rt_o,
  input  logic            wb_valid_i,
  input  logic [RA_W-1:0] wb_addr_i,
  input  logic            flags_valid_i,
  input  flagsALU         flags_alu_i,
  output modePC           mode_pc_o,
  output logic            flush_o,
  output logic            halt_core_o,
  output logic            illegal_o
);

  if (MUL_LAT < 2) begin : g_mul_lat_check
    $error("MUL_LAT must be at least 2");
  end

  decState state_q, state_d;
  logic is_bne_q, is_bne_d, illegal_q, illegal_d;
`ifdef DEC_MUL_MULTICYCLE_EN
  localparam int CntW = $clog2(MUL_LAT);
  logic [CntW-1:0] mul_cnt_q, mul_cnt_d;
`endif

  logic ex_valid_q, ex_valid_d, ex_imm_q, ex_imm_d, ex_wr_q, ex_wr_d;
  opCode ex_op_q, ex_op_d;
  funcALU ex_func_q, ex_func_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;

  logic [NUM_REGS-1:0] busy;
  logic fwd, hazard, out_free, issue, taken;

  // Immediate forms carry op[4]; they never read rt.
  always_comb begin
    fwd          = is_fwd_op(op_code_i);
    hazard       = fwd & (busy[rs_i] | (~op_code_i[4] & busy[rt_i]) |
                          (is_wr_op(op_code_i) & busy[rd_i]));
    out_free     = ~ex_valid_q | ex_ready_i;
    inst_ready_o = ~(inst_valid_i & hazard) & out_free & (state_q == S_RUN);
    issue        = inst_valid_i & inst_ready_o;
    taken        = (state_q == S_BRANCH) & flags_valid_i & (flags_alu_i.zero ^ is_bne_q);
  end

  dec_scoreboard #(.NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (issue & is_wr_op(op_code_i)),
    .set_addr_i (rd_i),
    .clr_en_i   (wb_valid_i),
    .clr_addr_i (wb_addr_i),
    .busy_o     (busy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RUN;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DEC_MUL_MULTICYCLE_EN
      mul_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_bne_q  <= is_bne_d;
      illegal_q <= illegal_d;
`ifdef DEC_MUL_MULTICYCLE_EN
      mul_cnt_q <= mul_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    is_bne_d  = is_bne_q;
    illegal_d = illegal_q;
`ifdef DEC_MUL_MULTICYCLE_EN
    mul_cnt_d = mul_cnt_q;
`endif
    case (state_q)
      S_RUN: begin
        if (issue) begin
          if (!fwd) begin
            state_d   = S_HALT;
            illegal_d = (op_code_i != OP_HALT);
          end else if (is_branch(op_code_i)) begin
            state_d  = S_BRANCH;
            is_bne_d = (op_code_i == OP_BNE);
          end
`ifdef DEC_MUL_MULTICYCLE_EN
          else if (is_mul(op_code_i)) begin
            state_d   = S_MUL;
            mul_cnt_d = CntW'(MUL_LAT - 1);
          end
`endif
        end
      end
      S_BRANCH: if (flags_valid_i) state_d = S_RUN;
`ifdef DEC_MUL_MULTICYCLE_EN
      // Leave as the counter hits zero so the next op issues MUL_LAT cycles after the MUL.
      S_MUL: begin
        mul_cnt_d = mul_cnt_q - CntW'(1);
        if (mul_cnt_q == CntW'(1)) state_d = S_RUN;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    mode_pc_o   = INCREMENT;
    flush_o     = 1'b0;
    halt_core_o = (state_q == S_HALT);
    illegal_o   = illegal_q;
    if (state_q == S_HALT) mode_pc_o = HALTCOUNT;
    else if (taken) begin
      mode_pc_o = RELATIVE;
      flush_o   = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_func_d  = ex_func_q;
    ex_imm_d   = ex_imm_q;
    ex_wr_d    = ex_wr_q;
    ex_rd_d    = ex_rd_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    if (out_free) ex_valid_d = issue & fwd;
    if (issue & fwd) begin
      ex_op_d   = op_code_i;
      ex_func_d = op_code_i[3] ? F_SUB : funcALU'(op_code_i[2:0]);
      ex_imm_d  = op_code_i[4];
      ex_wr_d   = is_wr_op(op_code_i);
      ex_rd_d   = rd_i;
      ex_rs_d   = rs_i;
      ex_rt_d   = rt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_ADD;
      ex_func_q  <= F_ADD;
      ex_imm_q   <= 1'b0;
      ex_wr_q    <= 1'b0;
      ex_rd_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_func_q  <= ex_func_d;
      ex_imm_q   <= ex_imm_d;
      ex_wr_q    <= ex_wr_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_op_o        = ex_op_q;
  assign ex_func_alu_o  = ex_func_q;
  assign ex_a_imm_alu_o = ex_imm_q;
  assign ex_wr_en_rf_o  = ex_wr_q;
  assign ex_rd_o        = ex_rd_q;
  assign ex_rs_o        = ex_rs_q;
  assign ex_rt_o        = ex_rt_q;

endmodule
